dmem_responder: RTL

Word-organised data-memory responder serving the core's load/store port: it accepts one request at a time over a req/ack handshake, commits byte-enabled writes, returns read words after a programmable wait-state delay, and flags out-of-range accesses. It sits between the core's `addr`/`din`/`data_we`/`dout` memory master and on-chip block RAM. It is the responder end of the data-memory interface that the core initiates.

---
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store handshake bundle between the core and dmem_responder
// Signals:
//   req  : request valid, held with addr/we/din until ack
//   addr : byte address
//   we   : byte write enables, 4'b0000 is a read
//   din  : write data
//   dout : read data, valid with ack
//   ack  : single-cycle response strobe
//   err  : access error, valid with ack
//   busy : responder is in WAIT or RESP
// Modports: master (core side), slave (responder side).
interface dmem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, addr, we, din,
    input  dout, ack, err, busy
  );

  modport slave (
    input  req, addr, we, din,
    output dout, ack, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data memory responder with wait states and byte enables
// Parameters:
//   ADDR_WIDTH  : word-index width, memory holds 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : dmem_responder_if.slave (req/addr/we/din in, dout/ack/err/busy out)
// Optional feature: define DMEM_RANGE_CHECK_EN to flag accesses whose upper
// address bits exceed the memory; without it addresses alias and err stays 0.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [3:0]  we_q;
  logic [31:0] din_q;
  logic [31:0] dout_q;
  logic        err_q;

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // With zero wait states the commit edge is the acceptance edge, so the
  // request is taken straight from the bus while IDLE; otherwise from latches.
  logic [31:0]           addr_eff;
  logic [3:0]            we_eff;
  logic [31:0]           din_eff;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  oor;
  logic                  commit;
  logic                  unused_addr_bits;

  assign addr_eff = (state_q == S_IDLE) ? bus.addr : addr_q;
  assign we_eff   = (state_q == S_IDLE) ? bus.we   : we_q;
  assign din_eff  = (state_q == S_IDLE) ? bus.din  : din_q;
  assign idx      = addr_eff[ADDR_WIDTH+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign oor = |addr_eff[31:ADDR_WIDTH+2];
`else
  assign oor = 1'b0;
`endif

  assign unused_addr_bits = ^{addr_eff[31:ADDR_WIDTH+2], addr_eff[1:0]};

  // Commit happens on the edge that enters RESP.
  assign commit = (state_d == S_RESP) && (state_q != S_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      we_q    <= 4'h0;
      din_q   <= 32'h0;
      dout_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && bus.req) begin
        addr_q <= bus.addr;
        we_q   <= bus.we;
        din_q  <= bus.din;
      end
      if (commit) begin
        err_q <= oor;
        if (oor) begin
          dout_q <= 32'h0;
        end else if (we_eff == 4'h0) begin
          dout_q <= mem[idx];
        end
      end
    end
  end

  // Memory is never reset; rst in the sensitivity list only blocks a commit
  // on an edge where reset is already high.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && commit && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (we_eff[i]) begin
          mem[idx][8*i +: 8] <= din_eff[8*i +: 8];
        end
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.ack  = (state_q == S_RESP);
  assign bus.err  = (state_q == S_RESP) & err_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule
